// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register stages: WB control bit positions and the
// default-width MEM/WB entry layout.
package pipe_pkg;

  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_RD_W   = 5;
  localparam int unsigned DEF_WB_W   = 2;

  typedef struct packed {
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_DATA_W-1:0] mem;
    logic [DEF_DATA_W-1:0] alu;
    logic [DEF_RD_W-1:0]   rd;
  } memwb_entry_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register; Skid=1 gives a 2-entry skid buffer with a registered
// in_ready, Skid=0 a single register with combinational in_ready.
module pipe_skid_reg #(
  parameter int unsigned Width = 8,
  parameter bit          Skid  = 1'b1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic             r_main_v;
  logic [Width-1:0] r_main;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_main_v & out_ready;
  assign out_valid  = r_main_v;
  assign out_data   = r_main;

  if (Skid) begin : g_skid
    logic             r_skid_v;
    logic [Width-1:0] r_skid;

    // Depends only on state, so out_ready never reaches in_ready combinationally.
    assign in_ready = ~r_skid_v;

    always_ff @(posedge clock) begin
      if (rst) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
        r_main   <= '0;
        r_skid   <= '0;
      end else begin
        if (!r_main_v) begin
          if (w_in_fire) begin
            r_main   <= in_data;
            r_main_v <= 1'b1;
          end
        end else if (!r_skid_v) begin
          if (w_in_fire && w_out_fire) begin
            r_main <= in_data;
          end else if (w_in_fire) begin
            r_skid   <= in_data;
            r_skid_v <= 1'b1;
          end else if (w_out_fire) begin
            r_main_v <= 1'b0;
          end
        end else if (w_out_fire) begin
          r_main   <= r_skid;
          r_skid_v <= 1'b0;
        end
        if (flush) begin
          r_main_v <= 1'b0;
          r_skid_v <= 1'b0;
        end
      end
    end
  end else begin : g_single
    assign in_ready = ~r_main_v | out_ready;

    always_ff @(posedge clock) begin
      if (rst) begin
        r_main_v <= 1'b0;
        r_main   <= '0;
      end else begin
        if (w_in_fire) begin
          r_main   <= in_data;
          r_main_v <= 1'b1;
        end else if (w_out_fire) begin
          r_main_v <= 1'b0;
        end
        if (flush) begin
          r_main_v <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/memwb_pipe_stage.sv
// MEM/WB pipeline stage: packs the entry into a valid/ready register and exposes a
// forwarding tap derived from the head entry only.
module memwb_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned WB_W   = 2,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [DATA_W-1:0] out_mem,
  output logic [DATA_W-1:0] out_alu,
  output logic [RD_W-1:0]   out_rd,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  if (WB_W < 2) begin : g_bad_wb_w
    $error("memwb_pipe_stage: WB_W must be at least 2");
  end

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic [RD_W-1:0]   rd;
  } stage_entry_t;

  localparam int unsigned ENTRY_W = $bits(stage_entry_t);

  stage_entry_t w_in_entry;
  stage_entry_t w_out_entry;

  assign w_in_entry = '{wb: in_wb, mem: in_mem, alu: in_alu, rd: in_rd};

  pipe_skid_reg #(
    .Width (ENTRY_W),
    .Skid  (SKID)
  ) u_reg (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_entry)
  );

  assign out_wb  = w_out_entry.wb;
  assign out_mem = w_out_entry.mem;
  assign out_alu = w_out_entry.alu;
  assign out_rd  = w_out_entry.rd;

  // Writes to r0 still flow to WB but must never be bypassed.
  assign fwd_valid = out_valid & out_wb[WB_REGWRITE] & (out_rd != '0);
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_wb[WB_MEMTOREG] ? out_mem : out_alu;

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Directed bench for memwb_pipe_stage: one SKID=1 instance and one SKID=0 instance.
module tb_memwb_pipe_stage;

  logic        clock = 1'b0;
  logic        rst;
  logic        flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_fwd_valid;
  logic [1:0]  a_in_wb, a_out_wb;
  logic [31:0] a_in_mem, a_in_alu, a_out_mem, a_out_alu, a_fwd_data;
  logic [4:0]  a_in_rd, a_out_rd, a_fwd_rd;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_fwd_valid;
  logic [1:0]  b_in_wb, b_out_wb;
  logic [31:0] b_in_mem, b_in_alu, b_out_mem, b_out_alu, b_fwd_data;
  logic [4:0]  b_in_rd, b_out_rd, b_fwd_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  memwb_pipe_stage #(.DATA_W(32), .RD_W(5), .WB_W(2), .SKID(1'b1)) dut_skid (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_wb     (a_in_wb),
    .in_mem    (a_in_mem),
    .in_alu    (a_in_alu),
    .in_rd     (a_in_rd),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_wb    (a_out_wb),
    .out_mem   (a_out_mem),
    .out_alu   (a_out_alu),
    .out_rd    (a_out_rd),
    .fwd_valid (a_fwd_valid),
    .fwd_rd    (a_fwd_rd),
    .fwd_data  (a_fwd_data)
  );

  memwb_pipe_stage #(.DATA_W(32), .RD_W(5), .WB_W(2), .SKID(1'b0)) dut_single (
    .clock     (clock),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_wb     (b_in_wb),
    .in_mem    (b_in_mem),
    .in_alu    (b_in_alu),
    .in_rd     (b_in_rd),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_wb    (b_out_wb),
    .out_mem   (b_out_mem),
    .out_alu   (b_out_alu),
    .out_rd    (b_out_rd),
    .fwd_valid (b_fwd_valid),
    .fwd_rd    (b_fwd_rd),
    .fwd_data  (b_fwd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [1:0] wb, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] rd);
    a_in_valid = v;
    a_in_wb    = wb;
    a_in_mem   = mem;
    a_in_alu   = alu;
    a_in_rd    = rd;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    a_drive(1'b1, 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
    a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_wb = 2'b11; b_in_mem = 32'h5;
    b_in_alu = 32'h6; b_in_rd = 5'd7; b_out_ready = 1'b0;

    // Reset held two cycles with in_valid asserted.
    step();
    step();
    rst = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_wb", a_out_wb, 2'b00);
    check("rst_out_mem", a_out_mem, 32'h0);
    check("rst_out_alu", a_out_alu, 32'h0);
    check("rst_out_rd", a_out_rd, 5'd0);
    check("rst_fwd_valid", a_fwd_valid, 1'b0);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_b_out_valid", b_out_valid, 1'b0);
    check("rst_b_in_ready", b_in_ready, 1'b1);

    // Streaming at one entry per cycle.
    a_out_ready = 1'b1;
    a_drive(1'b1, 2'b10, 32'h55, 32'hAA, 5'd5);
    step();
    check("stream0_valid", a_out_valid, 1'b1);
    check("stream0_alu", a_out_alu, 32'hAA);
    check("stream0_fwd_valid", a_fwd_valid, 1'b1);
    check("stream0_fwd_rd", a_fwd_rd, 5'd5);
    check("stream0_fwd_data", a_fwd_data, 32'hAA);
    a_drive(1'b1, 2'b10, 32'h0, 32'hBB, 5'd6);
    step();
    check("stream1_alu", a_out_alu, 32'hBB);
    check("stream1_rd", a_out_rd, 5'd6);
    check("stream1_in_ready", a_in_ready, 1'b1);
    a_in_valid = 1'b0;
    step();
    check("stream_drained", a_out_valid, 1'b0);

    // MemtoReg select and rd=0 suppression.
    a_drive(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h1, 5'd7);
    step();
    check("m2r_fwd_data", a_fwd_data, 32'hDEAD_BEEF);
    check("m2r_fwd_valid", a_fwd_valid, 1'b1);
    check("m2r_out_mem", a_out_mem, 32'hDEAD_BEEF);
    a_drive(1'b1, 2'b10, 32'h0, 32'h22, 5'd0);
    step();
    check("rd0_out_valid", a_out_valid, 1'b1);
    check("rd0_fwd_valid", a_fwd_valid, 1'b0);
    check("rd0_fwd_data", a_fwd_data, 32'h22);
    a_in_valid = 1'b0;
    step();
    check("rd0_drained", a_out_valid, 1'b0);

    // Backpressure: A, B fill the stage; C must be refused.
    a_out_ready = 1'b0;
    a_drive(1'b1, 2'b10, 32'h0, 32'hA1, 5'd1);
    step();
    check("bp_one_in_ready", a_in_ready, 1'b1);
    check("bp_one_alu", a_out_alu, 32'hA1);
    a_drive(1'b1, 2'b10, 32'h0, 32'hB2, 5'd2);
    step();
    check("bp_full_in_ready", a_in_ready, 1'b0);
    check("bp_full_head", a_out_alu, 32'hA1);
    a_drive(1'b1, 2'b10, 32'h0, 32'hC3, 5'd3);
    step();
    check("bp_stall_head", a_out_alu, 32'hA1);
    check("bp_stall_valid", a_out_valid, 1'b1);
    check("bp_stall_in_ready", a_in_ready, 1'b0);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("bp_b_alu", a_out_alu, 32'hB2);
    check("bp_b_rd", a_out_rd, 5'd2);
    check("bp_b_in_ready", a_in_ready, 1'b1);
    step();
    check("bp_drained", a_out_valid, 1'b0);

    // Flush while full, with a new entry offered.
    a_out_ready = 1'b0;
    a_drive(1'b1, 2'b10, 32'h0, 32'hD4, 5'd4);
    step();
    a_drive(1'b1, 2'b10, 32'h0, 32'hE5, 5'd5);
    step();
    check("fl_full_in_ready", a_in_ready, 1'b0);
    a_drive(1'b1, 2'b10, 32'h0, 32'hF6, 5'd6);
    flush = 1'b1;
    step();
    check("fl_out_valid", a_out_valid, 1'b0);
    check("fl_in_ready", a_in_ready, 1'b1);
    check("fl_fwd_valid", a_fwd_valid, 1'b0);
    flush = 1'b0;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    check("fl_nothing_emitted", a_out_valid, 1'b0);
    a_drive(1'b1, 2'b10, 32'h0, 32'h77, 5'd8);
    step();
    check("fl_after_valid", a_out_valid, 1'b1);
    check("fl_after_alu", a_out_alu, 32'h77);
    a_in_valid = 1'b0;
    step();

    // SKID=0: combinational in_ready and same-cycle head replacement.
    b_in_valid = 1'b1; b_in_wb = 2'b10; b_in_mem = 32'h0; b_in_alu = 32'h11; b_in_rd = 5'd3;
    b_out_ready = 1'b0;
    step();
    check("s0_valid", b_out_valid, 1'b1);
    check("s0_alu", b_out_alu, 32'h11);
    check("s0_in_ready_stall", b_in_ready, 1'b0);
    b_in_alu = 32'h22; b_in_rd = 5'd4;
    b_out_ready = 1'b1;
    #1;
    check("s0_in_ready_comb", b_in_ready, 1'b1);
    step();
    check("s0_replace_valid", b_out_valid, 1'b1);
    check("s0_replace_alu", b_out_alu, 32'h22);
    check("s0_replace_rd", b_out_rd, 5'd4);
    b_in_valid = 1'b0;
    step();
    check("s0_drained", b_out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
